// File: rtl/mips32_memsys.sv
// mips32_memsys: word RAM plus LED/cycle/timer I/O bank serving the mips32 core bus.
// Define MEMSYS_BUSSTAT_EN to add read/write access counters at I/O offsets 0x14/0x18.
module mips32_memsys #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    RAM_WORDS  = 192,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 10'h300,
    parameter string                 INIT_FILE  = "program.hex"
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  breq_,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic [ADDR_WIDTH-1:0] adr,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] memdata,
    output logic [7:0]            led,
    output logic                  timer_irq
);
    logic [DATA_WIDTH-1:0] mem [RAM_WORDS];
    logic [DATA_WIDTH-1:0] cycle, tcmp, tcnt, io_data;
    logic [ADDR_WIDTH-3:0] word;
    logic [5:0] off;
    logic ram_hit, io_hit, rd, wr, wr_io, match, en, reload, expired;
    logic unused;

    assign word    = adr[ADDR_WIDTH-1:2];
    assign off     = adr[7:2];
    assign ram_hit = (adr < MMIO_BASE) && (int'(word) < RAM_WORDS);
    assign io_hit  = adr[ADDR_WIDTH-1 -: 2] == 2'b11;
    assign rd      = !breq_ && memread;
    assign wr      = !breq_ && memwrite && !reset_;
    assign wr_io   = wr && io_hit;
    assign match   = en && (tcnt == tcmp);
    assign unused  = ^adr[1:0];
    assign timer_irq = expired;

    always_ff @(posedge clk)
        if (wr && ram_hit) mem[word] <= writedata;

    always_ff @(posedge clk) begin
        if (reset_) begin
            led     <= '0;
            cycle   <= '0;
            tcmp    <= '0;
            tcnt    <= '0;
            en      <= 1'b0;
            reload  <= 1'b0;
            expired <= 1'b0;
        end else begin
            cycle   <= cycle + 1'b1;
            if (wr_io && off == 6'd0) led <= writedata[7:0];
            if (wr_io && off == 6'd2) tcmp <= writedata;
            tcnt    <= (wr_io && off == 6'd3) ? writedata :
                       !en ? tcnt : match ? (reload ? '0 : tcnt) : tcnt + 1'b1;
            en      <= (wr_io && off == 6'd4) ? writedata[0] : en && !(match && !reload);
            reload  <= (wr_io && off == 6'd4) ? writedata[1] : reload;
            expired <= match || (expired && !(wr_io && off == 6'd4 && writedata[8]));
        end
    end

`ifdef MEMSYS_BUSSTAT_EN
    logic [DATA_WIDTH-1:0] rdcnt, wrcnt;

    always_ff @(posedge clk) begin
        if (reset_) begin
            rdcnt <= '0;
            wrcnt <= '0;
        end else begin
            if (rd) rdcnt <= rdcnt + 1'b1;
            if (!breq_ && memwrite) wrcnt <= wrcnt + 1'b1;
        end
    end
`endif

    always_comb begin
        io_data = '0;
        case (off)
            6'd0: io_data = DATA_WIDTH'(led);
            6'd1: io_data = cycle;
            6'd2: io_data = tcmp;
            6'd3: io_data = tcnt;
            6'd4: io_data = DATA_WIDTH'({expired, 6'b0, reload, en});
`ifdef MEMSYS_BUSSTAT_EN
            6'd5: io_data = rdcnt;
            6'd6: io_data = wrcnt;
`endif
            default: io_data = '0;
        endcase
    end

    assign memdata = !rd ? '0 : ram_hit ? mem[word] : io_hit ? io_data : '0;
endmodule

// File: tb/tb_mips32_memsys.sv
// tb_mips32_memsys: directed scoreboard bench for the mips32 memory subsystem.
module tb_mips32_memsys;
    logic clk = 1'b0;
    logic reset_, breq_, memread, memwrite, timer_irq;
    logic [9:0] adr;
    logic [31:0] writedata, memdata, cyc_model, c0;
    logic [7:0] led;
    logic [31:0] exp_q[$];
    string tag_q[$];
    int vecs = 0, errs = 0;

`ifdef MEMSYS_BUSSTAT_EN
    localparam logic [31:0] RDX = 32'd3, WRX = 32'd2;
`else
    localparam logic [31:0] RDX = 32'd0, WRX = 32'd0;
`endif

    mips32_memsys #(.INIT_FILE("")) dut (
        .clk(clk), .reset_(reset_), .breq_(breq_), .memread(memread), .memwrite(memwrite),
        .adr(adr), .writedata(writedata), .memdata(memdata), .led(led), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_model <= reset_ ? 32'd0 : cyc_model + 32'd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vecs++;
        assert (got === want) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic idle();
        breq_ = 1'b1; memread = 1'b0; memwrite = 1'b0; adr = '0; writedata = '0;
    endtask

    task automatic bus(input logic r, input logic w, input logic [9:0] a,
                       input logic [31:0] d, input logic [31:0] e, input string tag);
        breq_ = 1'b0; memread = r; memwrite = w; adr = a; writedata = d;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        chk(tag_q.pop_front(), memdata, exp_q.pop_front());
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        reset_ = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1 reset_ = 1'b0;
        bus(1, 0, 10'h304, 0, 32'd0, "cycle_first");
        chk("led_rst", 32'(led), 32'd0);
        chk("irq_rst", 32'(timer_irq), 32'd0);
        bus(1, 0, 10'h310, 0, 32'd0, "tctrl_rst");
        bus(0, 1, 10'h010, 32'hDEADBEEF, 0, "wr_ram");
        bus(1, 0, 10'h010, 0, 32'hDEADBEEF, "rd_ram");
        bus(1, 0, 10'h013, 0, 32'hDEADBEEF, "rd_ram_unaligned");
        bus(1, 1, 10'h010, 32'h11112222, 32'hDEADBEEF, "rdwr_old");
        bus(1, 0, 10'h010, 0, 32'h11112222, "rdwr_new");
        bus(0, 1, 10'h020, 32'h0BADF00D, 0, "wr_ram2");
        breq_ = 1'b1; memread = 1'b1; memwrite = 1'b1; adr = 10'h020; writedata = 32'h12345678;
        @(negedge clk);
        chk("gated_rd", memdata, 32'd0);
        @(posedge clk); #1;
        idle();
        bus(1, 0, 10'h020, 0, 32'h0BADF00D, "gated_wr");
        bus(0, 0, 10'h020, 0, 32'd0, "no_strobe");
        bus(1, 0, 10'h3F0, 0, 32'd0, "unmapped_rd");
        bus(0, 1, 10'h300, 32'h1A5, 0, "wr_led");
        chk("led_out", 32'(led), 32'hA5);
        bus(1, 0, 10'h300, 0, 32'hA5, "rd_led");
        bus(0, 1, 10'h3F0, 32'hFFFFFFFF, 0, "wr_unmapped");
        bus(1, 0, 10'h300, 0, 32'hA5, "led_kept");
        bus(1, 0, 10'h010, 0, 32'h11112222, "ram_kept");
        bus(0, 1, 10'h304, 32'h0, 0, "wr_cycle");
        c0 = cyc_model;
        bus(1, 0, 10'h304, 0, c0, "cycle_a");
        repeat (9) @(posedge clk);
        #1;
        bus(1, 0, 10'h304, 0, c0 + 32'd10, "cycle_b");
        bus(0, 1, 10'h308, 32'd5, 0, "wr_tcmp");
        bus(0, 1, 10'h30C, 32'd0, 0, "wr_tcnt");
        bus(0, 1, 10'h310, 32'h1, 0, "wr_tctrl_en");
        repeat (5) @(posedge clk);
        #1;
        chk("irq_early", 32'(timer_irq), 32'd0);
        @(posedge clk); #1;
        chk("irq_set", 32'(timer_irq), 32'd1);
        bus(1, 0, 10'h310, 0, 32'h100, "oneshot_ctrl");
        bus(1, 0, 10'h30C, 0, 32'd5, "oneshot_hold");
        bus(1, 0, 10'h30C, 0, 32'd5, "oneshot_hold2");
        bus(0, 1, 10'h310, 32'h100, 0, "w1c");
        chk("irq_clr", 32'(timer_irq), 32'd0);
        bus(1, 0, 10'h310, 0, 32'd0, "ctrl_clr");
        bus(0, 1, 10'h308, 32'd3, 0, "wr_tcmp3");
        bus(0, 1, 10'h30C, 32'd0, 0, "wr_tcnt0");
        bus(0, 1, 10'h310, 32'h3, 0, "wr_tctrl_reload");
        for (int i = 0; i < 6; i++) bus(1, 0, 10'h30C, 0, 32'(i % 4), "reload_seq");
        bus(1, 0, 10'h310, 0, 32'h103, "reload_exp");
        chk("irq_reload", 32'(timer_irq), 32'd1);
        bus(0, 1, 10'h310, 32'h103, 0, "w1c_on_match");
        bus(1, 0, 10'h310, 0, 32'h103, "set_beats_clear");
        bus(1, 0, 10'h30C, 0, 32'd1, "tcnt_1");
        bus(1, 0, 10'h30C, 0, 32'd2, "tcnt_2");
        bus(0, 1, 10'h30C, 32'd1, 0, "wr_tcnt_on_match");
        bus(1, 0, 10'h30C, 0, 32'd1, "tcnt_write_wins");
        bus(1, 0, 10'h30C, 0, 32'd2, "tcnt_after_write");
        reset_ = 1'b1; breq_ = 1'b0; memwrite = 1'b1; adr = 10'h300; writedata = 32'hFF;
        @(posedge clk); #1;
        reset_ = 1'b0;
        idle();
        bus(1, 0, 10'h304, 0, 32'd0, "cycle_after_rst");
        bus(1, 0, 10'h30C, 0, 32'd0, "tcnt_rst");
        bus(1, 0, 10'h300, 0, 32'd0, "led_write_dropped");
        bus(0, 1, 10'h3F0, 32'h1, 0, "wr_unmapped2");
        bus(0, 1, 10'h304, 32'h1, 0, "wr_cycle2");
        bus(1, 0, 10'h314, 0, RDX, "rdcnt");
        bus(1, 0, 10'h318, 0, WRX, "wrcnt");
        bus(1, 0, 10'h310, 0, 32'd0, "tctrl_rst2");
        bus(1, 0, 10'h308, 0, 32'd0, "tcmp_rst");
        chk("led_rst2", 32'(led), 32'd0);
        chk("irq_rst2", 32'(timer_irq), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
